// File: rtl/instruction_loader.sv
// Instruction loader: assembles a big-endian byte stream into 32-bit words
// and writes them to consecutive instruction memory addresses. A session
// ends on HALT_WORD, which is itself written, or once address DEPTH-1 has
// been written (full).
// Optional feature: define INSTRUCTION_LOADER_CHECKSUM_EN to build a
// running XOR checksum of all written words.
module instruction_loader #(
    parameter int unsigned DEPTH     = 32,
    parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        wr_instruction,
    output logic [31:0] wr_addr,
    output logic [31:0] data_instruction,
    output logic        busy,
    output logic        done,
    output logic        full,
    output logic [31:0] checksum
);

    localparam logic [31:0] LastAddr = 32'(DEPTH - 1);

    typedef enum logic [1:0] {StIdle, StRecv, StWrite, StDone} state_e;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q;
    logic [31:0] word_q;
    logic [31:0] addr_q;
    logic        full_q;
    logic        is_halt;
    logic        is_last;
    logic        session_start;

    assign is_halt          = (word_q == HALT_WORD);
    assign is_last          = (addr_q == LastAddr);
    assign session_start    = start && (state_q == StIdle || state_q == StDone);
    assign wr_addr          = addr_q;
    assign data_instruction = word_q;
    assign full             = full_q;

    // Next-state decode; rx_ready is high exactly in StRecv, so rx_valid alone qualifies a byte
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StDone: if (start) state_d = StRecv;
            StRecv:         if (rx_valid && cnt_q == 2'd3) state_d = StWrite;
            StWrite:        state_d = (is_halt || is_last) ? StDone : StRecv;
            default:        state_d = StIdle;
        endcase
    end

    // FSM state, datapath registers and registered status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StIdle;
            cnt_q          <= 2'd0;
            word_q         <= 32'd0;
            addr_q         <= 32'd0;
            full_q         <= 1'b0;
            rx_ready       <= 1'b0;
            wr_instruction <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            state_q        <= state_d;
            // Status flags follow the next state so they line up with state_q
            rx_ready       <= (state_d == StRecv);
            wr_instruction <= (state_d == StWrite);
            busy           <= (state_d == StRecv) || (state_d == StWrite);
            done           <= (state_d == StDone);
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        cnt_q  <= 2'd0;
                        word_q <= 32'd0;
                        addr_q <= 32'd0;
                        full_q <= 1'b0;
                    end
                end
                StRecv: begin
                    if (rx_valid) begin
                        // Shift left so the first byte ends up in [31:24]
                        word_q <= {word_q[23:0], rx_data};
                        cnt_q  <= cnt_q + 2'd1;
                    end
                end
                StWrite: begin
                    // Halt wins over the depth limit
                    if (!is_halt) begin
                        if (is_last) full_q <= 1'b1;
                        else         addr_q <= addr_q + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    logic [31:0] checksum_q;

    // Running XOR of every written word, cleared when a new session starts
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            checksum_q <= 32'd0;
        end else if (session_start) begin
            checksum_q <= 32'd0;
        end else if (state_q == StWrite) begin
            checksum_q <= checksum_q ^ word_q;
        end
    end

    assign checksum = checksum_q;
`else
    logic unused_start;
    assign unused_start = session_start;
    assign checksum     = 32'd0;
`endif

endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 Parameter: DEPTH, 32, number of instruction words the target memory holds; the last address is DEPTH-1.
REQ-002 Parameter: HALT_WORD, 32'hFFFFFFFF, the end-of-program marker.
REQ-003 The module SHALL provide port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 The module SHALL provide port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL provide port start, input, 1 bit: begins a load session; a one-cycle pulse is sufficient.
REQ-006 The module SHALL provide port rx_data, input, 8 bits: the incoming program byte.
REQ-007 The module SHALL provide port rx_valid, input, 1 bit: rx_data is valid this cycle.
REQ-008 The module SHALL provide port rx_ready, output, 1 bit: the loader accepts a byte this cycle.
REQ-009 The module SHALL provide port wr_instruction, output, 1 bit: write strobe to the instruction memory.
REQ-010 The module SHALL provide port wr_addr, output, 32 bits: the word address of the current write.
REQ-011 The module SHALL provide port data_instruction, output, 32 bits: the word being written.
REQ-012 The module SHALL provide port busy, output, 1 bit: a session is in progress.
REQ-013 The module SHALL provide port done, output, 1 bit: the session has ended.
REQ-014 The module SHALL provide port full, output, 1 bit: the session ended on the depth limit, not on HALT_WORD.
REQ-015 The module SHALL provide port checksum, output, 32 bits: the running XOR of the written words.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, RECV, WRITE and DONE; the reset state is IDLE.
REQ-017 IDLE or DONE with start=1 SHALL move the FSM to RECV, and on that same edge SHALL clear the word address, byte count, assembly register, full, done and checksum.
REQ-018 start SHALL be ignored while the FSM is in RECV or WRITE.
REQ-019 rx_ready SHALL equal 1 exactly when the FSM is in RECV; a byte transfers only on rx_valid=1 and rx_ready=1 in the same cycle.
REQ-020 rx_valid outside RECV SHALL be ignored, with no state change.
REQ-021 Bytes SHALL be assembled big-endian: the first byte of a word goes to [31:24] and the fourth byte to [7:0].
REQ-022 The 2-bit byte count SHALL wrap from 3 to 0.
REQ-023 On the edge that accepts the fourth byte, the FSM SHALL enter WRITE.
REQ-024 In WRITE, wr_instruction SHALL be 1 for exactly one cycle, with data_instruction equal to the assembled word and wr_addr equal to the current address.
REQ-025 wr_instruction SHALL be 0 in every state other than WRITE.
REQ-026 The latency from the fourth-byte handshake to the write strobe SHALL be exactly one cycle.
REQ-027 On the WRITE exit edge, if the word equals HALT_WORD, the FSM SHALL go to DONE with full=0; the HALT_WORD is itself written.
REQ-028 Otherwise, if wr_addr equals DEPTH-1, the FSM SHALL go to DONE with full=1.
REQ-029 Otherwise, the FSM SHALL increment wr_addr by 1 and return to RECV.
REQ-030 When a HALT_WORD lands at address DEPTH-1, the halt condition SHALL take priority and full SHALL be 0.
REQ-031 busy SHALL be 1 in RECV and WRITE.
REQ-032 done SHALL be 1 in DONE and held until the next start.
REQ-033 A partial word (1 to 3 bytes) SHALL never be written; it stays pending while the FSM is in RECV.

Reset
REQ-034 While rst=0, the FSM SHALL be in IDLE, and rx_ready, wr_instruction, busy, done and full SHALL all be 0.
REQ-035 While rst=0, wr_addr, data_instruction, checksum, the byte count and the assembly register SHALL all be 0.
REQ-036 A reset taken mid-session, including during WRITE, SHALL abort the session immediately with no further write strobe; a pending partial word is discarded.

Configuration
REQ-037 With macro INSTRUCTION_LOADER_CHECKSUM_EN defined, checksum SHALL be XORed with data_instruction on every WRITE cycle, HALT_WORD included.
REQ-038 With INSTRUCTION_LOADER_CHECKSUM_EN defined, checksum SHALL be cleared on start and on reset.
REQ-039 Without INSTRUCTION_LOADER_CHECKSUM_EN, checksum SHALL be constant 0 and no accumulator register is built.

Verification
REQ-040 Scenario: start, then bytes 00 22 18 20, FF FF FF FF -> writes addr0=32'h00221820 and addr1=32'hFFFFFFFF; then done=1, full=0, busy=0.
REQ-041 Scenario: 32 non-halt words -> 32 single-cycle strobes at addr 0..31, then done=1 and full=1; a 33rd word's bytes see rx_ready=0 and produce no write.
REQ-042 Scenario: rx_valid gaps of 0-5 idle cycles between bytes -> identical writes; each strobe occurs exactly one cycle after the fourth-byte handshake.
REQ-043 Scenario: rst pulled low after 2 bytes of word 3 -> all outputs 0 and IDLE; after release, start reloads from addr 0.
REQ-044 Scenario: start pulsed during RECV -> ignored, address unchanged; start in DONE -> new session at addr 0 with done cleared.
REQ-045 Scenario: with INSTRUCTION_LOADER_CHECKSUM_EN, words 12345678 and 0F0F0F0F followed by HALT_WORD -> checksum 32'hE2C4A688; without the macro, checksum stays 0.
